// File: rtl/traffic_phase_controller_pkg.sv
// Shared types and encodings for the traffic phase controller and its display path.
package traffic_phase_controller_pkg;

  localparam int unsigned CNT_W   = 7;
  localparam int unsigned LIGHT_W = 3;

  // Phase sequence; the one unused encoding recovers to CLR_B.
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    CLR_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    CLR_B     = 3'd5,
    FLASH     = 3'd6
  } phase_e;

  // Lamp encodings, bit order {red,yellow,green}.
  localparam logic [LIGHT_W-1:0] RED    = 3'b100;
  localparam logic [LIGHT_W-1:0] YELLOW = 3'b010;
  localparam logic [LIGHT_W-1:0] GREEN  = 3'b001;
  localparam logic [LIGHT_W-1:0] OFF    = 3'b000;

  // Count value that blanks the 7-segment display.
  localparam logic [CNT_W-1:0] BLANK = 7'h7F;

  // Everything the block presents to the lamps and displays.
  typedef struct packed {
    logic [LIGHT_W-1:0] ns_light;
    logic [LIGHT_W-1:0] ew_light;
    logic [CNT_W-1:0]   ns_count;
    logic [CNT_W-1:0]   ew_count;
  } display_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that flags the last tick of a phase.
module phase_timer #(
  parameter int unsigned     W       = 7,
  parameter logic [W-1:0]    RST_VAL = W'(1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         expire_c
);

  // Load wins over decrement; a count of 1 stays put so the owner can reload it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count > W'(1))) begin
      count <= count - W'(1);
    end
  end

  // Phase ends on the tick that finds the counter at 1.
  assign expire_c = tick && (count == W'(1));

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer with countdown displays and night flashing mode.
module traffic_phase_controller
  import traffic_phase_controller_pkg::*;
#(
  parameter int unsigned GREEN_T  = 30,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned RED_CLR  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               night_mode,
  output logic [LIGHT_W-1:0] ns_light,
  output logic [LIGHT_W-1:0] ew_light,
  output logic [CNT_W-1:0]   ns_count,
  output logic [CNT_W-1:0]   ew_count
);

  localparam logic [CNT_W-1:0] GREEN_D  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_D = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] RED_D    = CNT_W'(RED_CLR);
  localparam logic [CNT_W-1:0] YR_D     = CNT_W'(YELLOW_T + RED_CLR);

  phase_e           state;
  phase_e           state_next_c;
  logic             flash;
  logic             flash_next_c;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next_c;
  logic [CNT_W-1:0] load_value_c;
  logic             load_c;
  logic             run_tick_c;
  logic             expire_c;
  display_t         disp;
  display_t         disp_next_c;

  // Ticks only advance the normal cycle; night mode freezes the counter.
  assign run_tick_c = tick && !night_mode && (state != FLASH);

  phase_timer #(
    .W       (CNT_W),
    .RST_VAL (RED_D)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (run_tick_c),
    .load       (load_c),
    .load_value (load_value_c),
    .count      (count),
    .expire_c   (expire_c)
  );

  // Next phase and the duration loaded on entering it.
  always_comb begin
    state_next_c = state;
    load_c       = 1'b0;
    load_value_c = RED_D;
    if (night_mode) begin
      state_next_c = FLASH;
    end else begin
      case (state)
        NS_GREEN:  if (expire_c) begin state_next_c = NS_YELLOW; load_c = 1'b1; load_value_c = YELLOW_D; end
        NS_YELLOW: if (expire_c) begin state_next_c = CLR_A;     load_c = 1'b1; load_value_c = RED_D;    end
        CLR_A:     if (expire_c) begin state_next_c = EW_GREEN;  load_c = 1'b1; load_value_c = GREEN_D;  end
        EW_GREEN:  if (expire_c) begin state_next_c = EW_YELLOW; load_c = 1'b1; load_value_c = YELLOW_D; end
        EW_YELLOW: if (expire_c) begin state_next_c = CLR_B;     load_c = 1'b1; load_value_c = RED_D;    end
        CLR_B:     if (expire_c) begin state_next_c = NS_GREEN;  load_c = 1'b1; load_value_c = GREEN_D;  end
        FLASH: begin
          state_next_c = CLR_B;
          load_c       = 1'b1;
          load_value_c = RED_D;
        end
        default: begin
          state_next_c = CLR_B;
          load_c       = 1'b1;
          load_value_c = RED_D;
        end
      endcase
    end
  end

  // Counter value the timer will hold after this edge, so displays track it without lag.
  always_comb begin
    count_next_c = count;
    if (load_c) begin
      count_next_c = load_value_c;
    end else if (run_tick_c && (count > CNT_W'(1))) begin
      count_next_c = count - CNT_W'(1);
    end
  end

  // Flash yellow starts lit on entry and toggles per tick while flashing.
  always_comb begin
    flash_next_c = 1'b1;
    if (state == FLASH) begin
      flash_next_c = tick ? !flash : flash;
    end
  end

  // Lamp and countdown values for the phase being entered.
  always_comb begin
    disp_next_c.ns_light = RED;
    disp_next_c.ew_light = RED;
    disp_next_c.ns_count = count_next_c;
    disp_next_c.ew_count = count_next_c;
    case (state_next_c)
      NS_GREEN: begin
        disp_next_c.ns_light = GREEN;
        disp_next_c.ew_count = count_next_c + YR_D;
      end
      NS_YELLOW: begin
        disp_next_c.ns_light = YELLOW;
        disp_next_c.ew_count = count_next_c + RED_D;
      end
      EW_GREEN: begin
        disp_next_c.ew_light = GREEN;
        disp_next_c.ns_count = count_next_c + YR_D;
      end
      EW_YELLOW: begin
        disp_next_c.ew_light = YELLOW;
        disp_next_c.ns_count = count_next_c + RED_D;
      end
      FLASH: begin
        disp_next_c.ns_light = flash_next_c ? YELLOW : OFF;
        disp_next_c.ew_light = flash_next_c ? YELLOW : OFF;
        disp_next_c.ns_count = BLANK;
        disp_next_c.ew_count = BLANK;
      end
      default: begin
        disp_next_c.ns_light = RED;
        disp_next_c.ew_light = RED;
      end
    endcase
  end

  // Phase state, flash phase and registered outputs share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= CLR_B;
      flash         <= 1'b0;
      disp.ns_light <= RED;
      disp.ew_light <= RED;
      disp.ns_count <= RED_D;
      disp.ew_count <= RED_D;
    end else begin
      state <= state_next_c;
      flash <= flash_next_c;
      disp  <= disp_next_c;
    end
  end

  assign ns_light = disp.ns_light;
  assign ew_light = disp.ew_light;
  assign ns_count = disp.ns_count;
  assign ew_count = disp.ew_count;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: a 5/2/1 instance plus a default 30/3/2 instance.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       night_mode;
  logic       tick_d;
  logic       night_d;
  logic [2:0] ns_light, ew_light, ns_light_d, ew_light_d;
  logic [6:0] ns_count, ew_count, ns_count_d, ew_count_d;
  logic [19:0] obs, obs_d;
  logic [19:0] tbl [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs   = {ns_light, ew_light, ns_count, ew_count};
  assign obs_d = {ns_light_d, ew_light_d, ns_count_d, ew_count_d};

  traffic_phase_controller #(
    .GREEN_T  (5),
    .YELLOW_T (2),
    .RED_CLR  (1)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .night_mode (night_mode),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .ns_count   (ns_count),
    .ew_count   (ew_count)
  );

  traffic_phase_controller u_def (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick_d),
    .night_mode (night_d),
    .ns_light   (ns_light_d),
    .ew_light   (ew_light_d),
    .ns_count   (ns_count_d),
    .ew_count   (ew_count_d)
  );

  // One clock with optional tick pulses; samples 1 time unit after the edge and checks lamp safety.
  task automatic step(input logic t, input logic td);
    @(negedge clk);
    tick   = t;
    tick_d = td;
    @(posedge clk);
    #1;
    tick   = 1'b0;
    tick_d = 1'b0;
    checks++;
    if ((ns_light != 3'b100 && ew_light != 3'b100) &&
        !(ns_light == ew_light && (ns_light == 3'b010 || ns_light == 3'b000))) begin
      errors++;
      $display("FAIL overlap: ns_light=%b ew_light=%b required one road red", ns_light, ew_light);
    end
    checks++;
    if ((ns_light_d != 3'b100 && ew_light_d != 3'b100) &&
        !(ns_light_d == ew_light_d && (ns_light_d == 3'b010 || ns_light_d == 3'b000))) begin
      errors++;
      $display("FAIL overlap_def: ns_light=%b ew_light=%b required one road red", ns_light_d, ew_light_d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; night_mode = 1'b0; tick_d = 1'b0; night_d = 1'b0;
    #12;
    checks++;
    if (obs !== {3'b100, 3'b100, 7'd1, 7'd1}) begin
      errors++; $display("FAIL reset: got %h required %h", obs, {3'b100, 3'b100, 7'd1, 7'd1});
    end
    checks++;
    if (obs_d !== {3'b100, 3'b100, 7'd2, 7'd2}) begin
      errors++; $display("FAIL reset_def: got %h required %h", obs_d, {3'b100, 3'b100, 7'd2, 7'd2});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_first_tick();
    step(1'b0, 1'b0);
    checks++;
    if (obs !== {3'b100, 3'b100, 7'd1, 7'd1}) begin
      errors++; $display("FAIL hold_no_tick: got %h required %h", obs, {3'b100, 3'b100, 7'd1, 7'd1});
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== {3'b001, 3'b100, 7'd5, 7'd8}) begin
      errors++; $display("FAIL first_tick: got %h required %h", obs, {3'b001, 3'b100, 7'd5, 7'd8});
    end
  endtask

  task automatic test_full_cycle();
    tbl[0]  = {3'b001, 3'b100, 7'd4, 7'd7};
    tbl[1]  = {3'b001, 3'b100, 7'd3, 7'd6};
    tbl[2]  = {3'b001, 3'b100, 7'd2, 7'd5};
    tbl[3]  = {3'b001, 3'b100, 7'd1, 7'd4};
    tbl[4]  = {3'b010, 3'b100, 7'd2, 7'd3};
    tbl[5]  = {3'b010, 3'b100, 7'd1, 7'd2};
    tbl[6]  = {3'b100, 3'b100, 7'd1, 7'd1};
    tbl[7]  = {3'b100, 3'b001, 7'd8, 7'd5};
    tbl[8]  = {3'b100, 3'b001, 7'd7, 7'd4};
    tbl[9]  = {3'b100, 3'b001, 7'd6, 7'd3};
    tbl[10] = {3'b100, 3'b001, 7'd5, 7'd2};
    tbl[11] = {3'b100, 3'b001, 7'd4, 7'd1};
    tbl[12] = {3'b100, 3'b010, 7'd3, 7'd2};
    tbl[13] = {3'b100, 3'b010, 7'd2, 7'd1};
    tbl[14] = {3'b100, 3'b100, 7'd1, 7'd1};
    tbl[15] = {3'b001, 3'b100, 7'd5, 7'd8};
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== tbl[i]) begin
        errors++; $display("FAIL full_cycle_tick%0d: got %h required %h", i + 1, obs, tbl[i]);
      end
      step(1'b0, 1'b0);
      checks++;
      if (obs !== tbl[i]) begin
        errors++; $display("FAIL full_cycle_hold%0d: got %h required %h", i + 1, obs, tbl[i]);
      end
    end
  endtask

  task automatic test_night();
    repeat (8) step(1'b1, 1'b0);
    checks++;
    if (obs !== {3'b100, 3'b001, 7'd8, 7'd5}) begin
      errors++; $display("FAIL reach_ew_green: got %h required %h", obs, {3'b100, 3'b001, 7'd8, 7'd5});
    end
    night_mode = 1'b1;
    step(1'b1, 1'b0);
    checks++;
    if (obs !== {3'b010, 3'b010, 7'h7F, 7'h7F}) begin
      errors++; $display("FAIL flash_entry: got %h required %h", obs, {3'b010, 3'b010, 7'h7F, 7'h7F});
    end
    step(1'b0, 1'b0);
    checks++;
    if (obs !== {3'b010, 3'b010, 7'h7F, 7'h7F}) begin
      errors++; $display("FAIL flash_hold: got %h required %h", obs, {3'b010, 3'b010, 7'h7F, 7'h7F});
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== {3'b000, 3'b000, 7'h7F, 7'h7F}) begin
      errors++; $display("FAIL flash_tick1: got %h required %h", obs, {3'b000, 3'b000, 7'h7F, 7'h7F});
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== {3'b010, 3'b010, 7'h7F, 7'h7F}) begin
      errors++; $display("FAIL flash_tick2: got %h required %h", obs, {3'b010, 3'b010, 7'h7F, 7'h7F});
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== {3'b000, 3'b000, 7'h7F, 7'h7F}) begin
      errors++; $display("FAIL flash_tick3: got %h required %h", obs, {3'b000, 3'b000, 7'h7F, 7'h7F});
    end
  endtask

  task automatic test_night_exit();
    night_mode = 1'b0;
    step(1'b0, 1'b0);
    checks++;
    if (obs !== {3'b100, 3'b100, 7'd1, 7'd1}) begin
      errors++; $display("FAIL flash_exit: got %h required %h", obs, {3'b100, 3'b100, 7'd1, 7'd1});
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== {3'b001, 3'b100, 7'd5, 7'd8}) begin
      errors++; $display("FAIL resume_ns_green: got %h required %h", obs, {3'b001, 3'b100, 7'd5, 7'd8});
    end
  endtask

  task automatic test_held_tick();
    @(negedge clk);
    tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 tick = 1'b0;
    checks++;
    if (obs !== {3'b001, 3'b100, 7'd2, 7'd5}) begin
      errors++; $display("FAIL held_tick: got %h required %h", obs, {3'b001, 3'b100, 7'd2, 7'd5});
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (obs !== {3'b010, 3'b100, 7'd2, 7'd3}) begin
      errors++; $display("FAIL ns_yellow_entry: got %h required %h", obs, {3'b010, 3'b100, 7'd2, 7'd3});
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== {3'b100, 3'b100, 7'd1, 7'd1}) begin
      errors++; $display("FAIL async_reset: got %h required %h", obs, {3'b100, 3'b100, 7'd1, 7'd1});
    end
    checks++;
    if (obs_d !== {3'b100, 3'b100, 7'd2, 7'd2}) begin
      errors++; $display("FAIL async_reset_def: got %h required %h", obs_d, {3'b100, 3'b100, 7'd2, 7'd2});
    end
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if (obs !== {3'b100, 3'b100, 7'd1, 7'd1}) begin
      errors++; $display("FAIL post_reset_hold: got %h required %h", obs, {3'b100, 3'b100, 7'd1, 7'd1});
    end
    step(1'b1, 1'b0);
    checks++;
    if (obs !== {3'b001, 3'b100, 7'd5, 7'd8}) begin
      errors++; $display("FAIL post_reset_tick: got %h required %h", obs, {3'b001, 3'b100, 7'd5, 7'd8});
    end
  endtask

  task automatic test_defaults();
    step(1'b0, 1'b1);
    checks++;
    if (obs_d !== {3'b100, 3'b100, 7'd1, 7'd1}) begin
      errors++; $display("FAIL def_clr_dec: got %h required %h", obs_d, {3'b100, 3'b100, 7'd1, 7'd1});
    end
    step(1'b0, 1'b1);
    checks++;
    if (obs_d !== {3'b001, 3'b100, 7'd30, 7'd35}) begin
      errors++; $display("FAIL def_green_entry: got %h required %h", obs_d, {3'b001, 3'b100, 7'd30, 7'd35});
    end
    repeat (29) step(1'b0, 1'b1);
    checks++;
    if (obs_d !== {3'b001, 3'b100, 7'd1, 7'd6}) begin
      errors++; $display("FAIL def_last_green: got %h required %h", obs_d, {3'b001, 3'b100, 7'd1, 7'd6});
    end
    step(1'b0, 1'b1);
    checks++;
    if (obs_d !== {3'b010, 3'b100, 7'd3, 7'd5}) begin
      errors++; $display("FAIL def_yellow_entry: got %h required %h", obs_d, {3'b010, 3'b100, 7'd3, 7'd5});
    end
    checks++;
    if (obs !== {3'b001, 3'b100, 7'd5, 7'd8}) begin
      errors++; $display("FAIL idle_hold: got %h required %h", obs, {3'b001, 3'b100, 7'd5, 7'd8});
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_full_cycle();
    test_night();
    test_night_exit();
    test_held_tick();
    test_async_reset();
    test_defaults();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL provide parameter GREEN_T, default 30, green duration in ticks.
REQ-003 The block SHALL provide parameter YELLOW_T, default 3, yellow duration in ticks.
REQ-004 The block SHALL provide parameter RED_CLR, default 2, all-red clearance in ticks; legal ranges are each value >= 1 and GREEN_T+YELLOW_T+RED_CLR <= 99.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port tick, input, 1 bit: one-clk-wide 1 Hz enable pulse.
REQ-008 The block SHALL have port night_mode, input, 1 bit: level, requests flashing-yellow operation.
REQ-009 The block SHALL have port ns_light, output, 3 bits: {red,yellow,green}, one-hot or all-zero.
REQ-010 The block SHALL have port ew_light, output, 3 bits: {red,yellow,green}, one-hot or all-zero.
REQ-011 The block SHALL have port ns_count, output, 7 bits: seconds remaining for the NS road, 7'h7F = blank; it drives the 7-segment decoder.
REQ-012 The block SHALL have port ew_count, output, 7 bits: as ns_count for the EW road.

Function
REQ-013 States SHALL be NS_GREEN, NS_YELLOW, CLR_A, EW_GREEN, EW_YELLOW, CLR_B and FLASH.
REQ-014 Normal cycle SHALL be NS_GREEN->NS_YELLOW->CLR_A->EW_GREEN->EW_YELLOW->CLR_B->NS_GREEN.
REQ-015 A 7-bit phase counter SHALL load the phase duration (GREEN_T/YELLOW_T/RED_CLR) on phase entry.
REQ-016 On tick, a counter value >1 SHALL decrement it; a counter value of 1 SHALL advance the state and load the next duration in the same clk.
REQ-017 Without tick, the state and counter SHALL hold.
REQ-018 Lights: the green/yellow road SHALL show its colour while the other road shows red; CLR_A/CLR_B SHALL show both red.
REQ-019 The active road count SHALL equal the counter.
REQ-020 The red road count SHALL equal counter+YELLOW_T+RED_CLR in GREEN phases, counter+RED_CLR in YELLOW phases, and the counter in CLR phases.
REQ-021 Count arithmetic SHALL be unsigned 7-bit; the parameter legality rule guarantees no overflow and a value <= 99.
REQ-022 All outputs SHALL be registered and updated on the same clk edge as the state/counter.
REQ-023 night_mode=1 SHALL force FLASH on the next clk edge, from any state, regardless of tick.
REQ-024 In FLASH, lights red/green SHALL be 0 and both yellow bits SHALL be equal and toggle on each tick; FLASH entry value is yellow on; both counts SHALL be 7'h7F.
REQ-025 night_mode=0 while in FLASH SHALL move to CLR_B on the next clk with the counter = RED_CLR, then resume the normal cycle at NS_GREEN.
REQ-026 tick coincident with night_mode asserting SHALL give night_mode priority; no decrement occurs.
REQ-027 tick held high for multiple clks SHALL decrement on every clk; the tick source guarantees single-cycle pulses.
REQ-028 The block SHALL never allow both roads non-red, except in FLASH, including on any illegal state encoding, which SHALL recover to CLR_B.

Reset
REQ-029 rst_n=0 SHALL immediately force state CLR_B, counter=RED_CLR, ns_light=ew_light=3'b100 and ns_count=ew_count=RED_CLR.
REQ-030 Reset asserted mid-phase SHALL discard all progress; after release the first tick decrements from RED_CLR.
REQ-031 Reset deassertion SHALL require no tick alignment.

Structure
REQ-032 A shared package SHALL hold the state enum, the light encodings (RED=3'b100, YELLOW=3'b010, GREEN=3'b001, OFF=3'b000) and BLANK=7'h7F, for reuse by the display path.
REQ-033 One sub-module, phase_timer, SHALL be instantiated for the loadable down-counter with load value, tick, and expire (counter==1 && tick) signals.
REQ-034 No other hierarchy SHALL be present; the FSM and count computation SHALL reside in traffic_phase_controller.

Verification (GREEN_T=5, YELLOW_T=2, RED_CLR=1 unless noted)
REQ-035 Reset then 1 tick -> NS_GREEN, ns_light=001, ew_light=100, ns_count=5, ew_count=8.
REQ-036 Full cycle of 16 ticks from NS_GREEN -> state sequence of 5/2/1/5/2/1 ticks, back at NS_GREEN with ns_count=5; no overlap of non-red lights at any clk.
REQ-037 night_mode=1 in EW_GREEN with tick on the same clk -> next clk FLASH, lights 010/010, counts 7F/7F; 3 ticks -> yellow off, on, off.
REQ-038 night_mode=0 in FLASH -> CLR_B (100/100, counts 1/1); next tick -> NS_GREEN 5/8.
REQ-039 rst_n pulsed low mid NS_YELLOW between clk edges -> outputs reach the reset values asynchronously, before the next clk.
REQ-040 Defaults 30/3/2 -> first NS_GREEN ew_count=35, decrementing to 6 at the last green tick, then 5 at NS_YELLOW entry.
